// File: rtl/sha256_ctrl_fsm.sv
// SHA-256 sequencing FSM: padding, block-count load, length insertion, init, rounds, update, done.
// Optional macro SHA256_PRIME_STATE_EN inserts the one-cycle PRIME bubble before each block.
//
// state | meaning
// ------+----------------------------------------------
//   0   | IDLE      wait for start
//   1   | PAD       wait for padding_done
//   2   | LOAD_NUM  latch block count, clear block index
//   3   | LEN_LO    insert message length, low word
//   4   | LEN_HI    insert message length, high word
//   5   | INIT      load initial hash values
//   6   | PRIME     schedule-prime bubble (optional)
//   7   | ROUND     ROUNDS compression rounds
//   8   | UPDATE    fold working vars into hash
//   9   | DONE      hold until start is released
module sha256_ctrl_fsm #(
  parameter int ROUNDS = 64,
  parameter int RND_W  = 6,
  parameter int BLK_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             padding_done,
  input  logic [BLK_W-1:0] blocks_num,
  output logic [3:0]       state,
  output logic [RND_W-1:0] round_idx,
  output logic [BLK_W-1:0] block_idx,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PAD      = 4'd1,
    S_LOAD_NUM = 4'd2,
    S_LEN_LO   = 4'd3,
    S_LEN_HI   = 4'd4,
    S_INIT     = 4'd5,
    S_PRIME    = 4'd6,
    S_ROUND    = 4'd7,
    S_UPDATE   = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

`ifdef SHA256_PRIME_STATE_EN
  localparam state_t BLK_ENTRY = S_PRIME;
`else
  localparam state_t BLK_ENTRY = S_ROUND;
`endif

  logic [3:0]       state_q;
  state_t           state_d;
  logic [RND_W-1:0] round_d;
  logic [BLK_W-1:0] block_d;
  logic [BLK_W-1:0] blk_cnt_q;
  logic [BLK_W-1:0] blk_cnt_d;
  logic             last_block;

  // Compared one bit wider so an index already at the end cannot wrap back to zero.
  assign last_block = ({1'b0, block_idx} + (BLK_W+1)'(1)) >= {1'b0, blk_cnt_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= 4'd0;
      round_idx <= '0;
      block_idx <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      round_idx <= round_d;
      block_idx <= block_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_t'(state_q);
    round_d   = round_idx;
    block_d   = block_idx;
    blk_cnt_d = blk_cnt_q;
    case (state_t'(state_q))
      S_IDLE:     if (start) state_d = S_PAD;
      S_PAD:      if (padding_done) state_d = S_LOAD_NUM;
      S_LOAD_NUM: begin
        blk_cnt_d = blocks_num;
        block_d   = '0;
        state_d   = (blocks_num == '0) ? S_DONE : S_LEN_LO;
      end
      S_LEN_LO:   state_d = S_LEN_HI;
      S_LEN_HI:   state_d = S_INIT;
      S_INIT: begin
        round_d = '0;
        state_d = BLK_ENTRY;
      end
`ifdef SHA256_PRIME_STATE_EN
      S_PRIME:    state_d = S_ROUND;
`endif
      S_ROUND: begin
        if (round_idx == LAST_RND) state_d = S_UPDATE;
        else                       round_d = round_idx + RND_W'(1);
      end
      S_UPDATE: begin
        round_d = '0;
        if (last_block) begin
          state_d = S_DONE;
        end else begin
          block_d = block_idx + BLK_W'(1);
          state_d = BLK_ENTRY;
        end
      end
      S_DONE:     if (!start) state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        round_d   = '0;
        block_d   = '0;
        blk_cnt_d = '0;
      end
    endcase
    if (abort && (state_q != 4'd0)) begin
      state_d   = S_IDLE;
      round_d   = '0;
      block_d   = '0;
      blk_cnt_d = '0;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != 4'd0) && (state_q != 4'd9);

endmodule
